// File: rtl/ann_load_scheduler.sv
// Sequences node, leaf and query loads through the FIFO -> aggregator path,
// one whole word at a time, and steers each aggregated word to its memory.
module ann_load_scheduler #(
  parameter int NODE_FETCH_WIDTH  = 2,
  parameter int LEAF_FETCH_WIDTH  = 5,
  parameter int QUERY_FETCH_WIDTH = 5,
  parameter int NODE_WORDS        = 31,
  parameter int LEAF_WORDS        = 64,
  parameter int QUERY_WORDS       = 64,
  parameter int ADDR_WIDTH        = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  agg_sender_deq,
  input  logic                  agg_receiver_enq,
  output logic                  agg_gate,
  output logic                  agg_change_fetch_width,
  output logic [2:0]            agg_input_fetch_width,
  output logic                  node_wen,
  output logic                  leaf_wen,
  output logic                  query_wen,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]            phase,
  output logic                  busy,
  output logic                  done
);

  localparam int NODE_BEATS  = NODE_WORDS * NODE_FETCH_WIDTH;
  localparam int LEAF_BEATS  = LEAF_WORDS * LEAF_FETCH_WIDTH;
  localparam int QUERY_BEATS = QUERY_WORDS * QUERY_FETCH_WIDTH;
  localparam int MAX_NL      = (NODE_BEATS > LEAF_BEATS) ? NODE_BEATS : LEAF_BEATS;
  localparam int MAX_BEATS   = (MAX_NL > QUERY_BEATS) ? MAX_NL : QUERY_BEATS;
  localparam int BEAT_W      = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_LOAD, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_WIDTH:0] word_q, word_d;
  logic [1:0]          nph;

  function automatic int words_of(input logic [1:0] p);
    case (p)
      2'd0:    words_of = NODE_WORDS;
      2'd1:    words_of = LEAF_WORDS;
      2'd2:    words_of = QUERY_WORDS;
      default: words_of = 0;
    endcase
  endfunction

  function automatic int beats_of(input logic [1:0] p);
    case (p)
      2'd0:    beats_of = NODE_BEATS;
      2'd1:    beats_of = LEAF_BEATS;
      2'd2:    beats_of = QUERY_BEATS;
      default: beats_of = 0;
    endcase
  endfunction

  function automatic logic [2:0] width_of(input logic [1:0] p);
    case (p)
      2'd0:    width_of = 3'(NODE_FETCH_WIDTH);
      2'd1:    width_of = 3'(LEAF_FETCH_WIDTH);
      2'd2:    width_of = 3'(QUERY_FETCH_WIDTH);
      default: width_of = 3'd0;
    endcase
  endfunction

  // First non-empty phase at or after 'from'; 3 when nothing is left to load.
  function automatic logic [1:0] next_phase(input logic [2:0] from);
    next_phase = 2'd3;
    for (int p = 2; p >= 0; p--) begin
      if (p >= int'(from) && words_of(2'(p)) > 0) next_phase = 2'(p);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 2'd3;
      beat_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    phase_d                = phase_q;
    beat_d                 = beat_q;
    word_d                 = word_q;
    nph                    = 2'd3;
    agg_gate               = 1'b0;
    agg_change_fetch_width = 1'b0;
    agg_input_fetch_width  = 3'd0;
    node_wen               = 1'b0;
    leaf_wen               = 1'b0;
    query_wen              = 1'b0;
    wr_addr                = '0;
    phase                  = 2'd3;
    busy                   = 1'b0;
    done                   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nph = next_phase(3'd0);
          if (nph == 2'd3) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_CFG;
            phase_d = nph;
          end
        end
      end

      S_CFG: begin
        busy                   = 1'b1;
        phase                  = phase_q;
        agg_change_fetch_width = 1'b1;
        agg_input_fetch_width  = width_of(phase_q);
        beat_d                 = '0;
        word_d                 = '0;
        state_d                = S_LOAD;
      end

      S_LOAD: begin
        busy  = 1'b1;
        phase = phase_q;
        // Gate closes the cycle after the final beat so no partial word leaks in.
        agg_gate = (int'(beat_q) < beats_of(phase_q));
        if (agg_sender_deq) beat_d = beat_q + 1'b1;
        if (agg_receiver_enq) begin
          node_wen  = (phase_q == 2'd0);
          leaf_wen  = (phase_q == 2'd1);
          query_wen = (phase_q == 2'd2);
          wr_addr   = word_q[ADDR_WIDTH-1:0];
          word_d    = word_q + 1'b1;
          if (int'(word_q) == words_of(phase_q) - 1) begin
            nph = next_phase({1'b0, phase_q} + 3'd1);
            if (nph == 2'd3) begin
              state_d = S_FINISH;
              phase_d = 2'd3;
            end else begin
              state_d = S_CFG;
              phase_d = nph;
            end
          end
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        phase_d = 2'd3;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ann_load_scheduler.sv
// Directed bench: three scheduler configurations driven by a behavioural aggregator.
module tb_ann_load_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        fifo_ok;
  logic        force_enq;

  logic        gate [3];
  logic        cfw  [3];
  logic [2:0]  ifw  [3];
  logic        nwen [3];
  logic        lwen [3];
  logic        qwen [3];
  logic [11:0] waddr[3];
  logic [1:0]  ph   [3];
  logic        busy [3];
  logic        done [3];
  logic        deq  [3];
  logic        enq  [3];

  int checks = 0;
  int errors = 0;

  // aggregator model state
  int   agg_cnt[3];
  int   agg_w  [3];
  logic enq_r  [3];

  // event logs
  int         cfg_n[3];
  int         cfg_log[3][8];
  int         w_n[3];
  int         w_log[3][16];
  int         deq_n[3];
  int         done_n[3];
  int         gate_n[3];
  int         p_n[3];
  int         p_log[3][8];
  int         leaf_deq_n;
  logic [1:0] last_ph[3];

  ann_load_scheduler #(.NODE_WORDS(3), .LEAF_WORDS(2), .QUERY_WORDS(2)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .agg_sender_deq(deq[0]), .agg_receiver_enq(enq[0]),
    .agg_gate(gate[0]), .agg_change_fetch_width(cfw[0]), .agg_input_fetch_width(ifw[0]),
    .node_wen(nwen[0]), .leaf_wen(lwen[0]), .query_wen(qwen[0]), .wr_addr(waddr[0]),
    .phase(ph[0]), .busy(busy[0]), .done(done[0]));

  ann_load_scheduler #(.NODE_WORDS(3), .LEAF_WORDS(0), .QUERY_WORDS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .agg_sender_deq(deq[1]), .agg_receiver_enq(enq[1]),
    .agg_gate(gate[1]), .agg_change_fetch_width(cfw[1]), .agg_input_fetch_width(ifw[1]),
    .node_wen(nwen[1]), .leaf_wen(lwen[1]), .query_wen(qwen[1]), .wr_addr(waddr[1]),
    .phase(ph[1]), .busy(busy[1]), .done(done[1]));

  ann_load_scheduler #(.NODE_WORDS(0), .LEAF_WORDS(0), .QUERY_WORDS(0)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .agg_sender_deq(deq[2]), .agg_receiver_enq(enq[2]),
    .agg_gate(gate[2]), .agg_change_fetch_width(cfw[2]), .agg_input_fetch_width(ifw[2]),
    .node_wen(nwen[2]), .leaf_wen(lwen[2]), .query_wen(qwen[2]), .wr_addr(waddr[2]),
    .phase(ph[2]), .busy(busy[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      deq[d] = gate[d] & fifo_ok;
      enq[d] = enq_r[d] | force_enq;
    end
  end

  // Aggregator: latches width on the CFG pulse, emits a word strobe after 'width' beats.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        agg_cnt[d] <= 0;
        agg_w[d]   <= 0;
        enq_r[d]   <= 1'b0;
      end else begin
        enq_r[d] <= 1'b0;
        if (cfw[d]) agg_w[d] <= int'(ifw[d]);
        if (deq[d]) begin
          if (agg_cnt[d] + 1 == agg_w[d]) begin
            agg_cnt[d] <= 0;
            enq_r[d]   <= 1'b1;
          end else begin
            agg_cnt[d] <= agg_cnt[d] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cfw[d]) begin
        if (cfg_n[d] < 8) cfg_log[d][cfg_n[d]] <= int'(ifw[d]);
        cfg_n[d] <= cfg_n[d] + 1;
      end
      if (nwen[d] | lwen[d] | qwen[d]) begin
        if (w_n[d] < 16)
          w_log[d][w_n[d]] <= (lwen[d] ? 100 : 0) + (qwen[d] ? 200 : 0) + int'(waddr[d]);
        w_n[d] <= w_n[d] + 1;
      end
      if (deq[d])  deq_n[d]  <= deq_n[d] + 1;
      if (done[d]) done_n[d] <= done_n[d] + 1;
      if (gate[d]) gate_n[d] <= gate_n[d] + 1;
      if (ph[d] != last_ph[d]) begin
        if (p_n[d] < 8) p_log[d][p_n[d]] <= int'(ph[d]);
        p_n[d]     <= p_n[d] + 1;
        last_ph[d] <= ph[d];
      end
    end
    if (deq[0] && ph[0] == 2'd1) leaf_deq_n <= leaf_deq_n + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) begin
      cfg_n[d] = 0; w_n[d] = 0; deq_n[d] = 0; done_n[d] = 0;
      gate_n[d] = 0; p_n[d] = 0; last_ph[d] = 2'd3;
    end
    leaf_deq_n = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Waits for dut d to report done; optional random FIFO stalls and a restart attempt.
  task automatic wait_done(input int d, input bit rnd, input int restart_at);
    int k;
    k = 0;
    while (done_n[d] == 0 && k < 2000) begin
      @(posedge clk); #1;
      if (rnd) fifo_ok = 1'($urandom_range(0, 1));
      start = (k == restart_at);
      k++;
    end
    start   = 1'b0;
    fifo_ok = 1'b1;
    chk("job_completes_in_budget", int'(done_n[d] > 0), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic chk_full_job(input string tag);
    int ew[7];
    ew = '{0, 1, 2, 100, 101, 200, 201};
    chk({tag, "_cfg_n"}, cfg_n[0], 3);
    chk({tag, "_cfg0"}, cfg_log[0][0], 2);
    chk({tag, "_cfg1"}, cfg_log[0][1], 5);
    chk({tag, "_cfg2"}, cfg_log[0][2], 5);
    chk({tag, "_wen_n"}, w_n[0], 7);
    for (int i = 0; i < 7; i++) chk($sformatf("%s_write%0d", tag, i), w_log[0][i], ew[i]);
    chk({tag, "_deq_n"}, deq_n[0], 26);
    chk({tag, "_done_n"}, done_n[0], 1);
    chk({tag, "_busy_end"}, int'(busy[0]), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fifo_ok = 1'b1; force_enq = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_phase", int'(ph[0]), 3);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_gate", int'(gate[0]), 0);
    chk("rst_cfw", int'(cfw[0]), 0);
    chk("rst_ifw", int'(ifw[0]), 0);
    chk("rst_wen", int'(nwen[0] | lwen[0] | qwen[0]), 0);
    chk("rst_addr", int'(waddr[0]), 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();

    // Job with FIFO always full: check start latency, then full traces.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("lat_cfg_pulse", int'(cfw[0]), 1);
    chk("lat_cfg_width", int'(ifw[0]), 2);
    chk("lat_phase", int'(ph[0]), 0);
    chk("lat_busy", int'(busy[0]), 1);
    chk("lat_gate_in_cfg", int'(gate[0]), 0);
    chk("zero_done_2nd_cycle", int'(done[2]), 1);
    chk("zero_busy", int'(busy[2]), 0);
    wait_done(0, 1'b0, -1);
    wait_done(1, 1'b0, -1);
    chk_full_job("full");
    chk("full_phase_n", p_n[0], 4);
    chk("full_phase_seq0", p_log[0][0], 0);
    chk("full_phase_seq1", p_log[0][1], 1);
    chk("full_phase_seq2", p_log[0][2], 2);
    chk("full_phase_seq3", p_log[0][3], 3);

    // Empty leaf phase skipped.
    chk("skip_cfg_n", cfg_n[1], 2);
    chk("skip_cfg1", cfg_log[1][1], 5);
    chk("skip_wen_n", w_n[1], 5);
    chk("skip_write3", w_log[1][3], 200);
    chk("skip_write4", w_log[1][4], 201);
    chk("skip_deq_n", deq_n[1], 16);
    chk("skip_phase_n", p_n[1], 3);
    chk("skip_phase_seq1", p_log[1][1], 2);
    chk("skip_done_n", done_n[1], 1);

    // All-empty job.
    chk("zero_cfg_n", cfg_n[2], 0);
    chk("zero_gate_n", gate_n[2], 0);
    chk("zero_wen_n", w_n[2], 0);
    chk("zero_done_n", done_n[2], 1);

    // Random FIFO stalls plus a second start while loading.
    clear_logs();
    pulse_start();
    wait_done(0, 1'b1, 10);
    chk_full_job("stall");

    // Reset in the middle of the leaf phase.
    clear_logs();
    pulse_start();
    for (int k = 0; k < 500 && leaf_deq_n < 3; k++) begin
      @(negedge clk); #1;
    end
    chk("mid_leaf_reached", leaf_deq_n, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_phase", int'(ph[0]), 3);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_gate", int'(gate[0]), 0);
    chk("abort_cfw", int'(cfw[0]), 0);
    chk("abort_wen", int'(nwen[0] | lwen[0] | qwen[0]), 0);
    chk("abort_addr", int'(waddr[0]), 0);
    @(negedge clk); #1;
    chk("abort_no_done", done_n[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    pulse_start();
    wait_done(0, 1'b0, -1);
    chk_full_job("restart");

    // Stray word strobe while idle.
    @(posedge clk); #1 force_enq = 1'b1;
    @(negedge clk);
    chk("stray_enq_wen", int'(nwen[0] | lwen[0] | qwen[0]), 0);
    chk("stray_enq_phase", int'(ph[0]), 3);
    @(posedge clk); #1 force_enq = 1'b0;
    @(negedge clk); #1;
    chk("stray_enq_log", w_n[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
